// File: rtl/hs4_pkg.sv
// hs4_pkg: state encoding and helpers shared by the 4-phase bundled-data bridges.
`default_nettype none

package hs4_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] REQ_HI = 2'd2;
  localparam logic [1:0] REQ_LO = 2'd3;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_nff.sv
// sync_nff: STAGES-deep single-bit synchroniser, synchronous active-low reset to 0.
`default_nettype none

module sync_nff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (!rstn) ff <= '0;
    else       ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/hs4_tx_bridge.sv
// hs4_tx_bridge: valid/ready source into a 4-phase bundled-data req/ack channel,
// with a small FIFO, programmable bundling margin and synchronised ack.
`default_nettype none

module hs4_tx_bridge
  import hs4_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int SETUP_CYC   = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     req_o,
  output logic [WIDTH-1:0]         data_o,
  input  logic                     ack_i,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW    = clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int CNT_W = (SETUP_CYC > 1) ? clog2(SETUP_CYC) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             ack_s;
  logic             push;
  logic             pop;

  sync_nff #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (ack_i),
    .q    (ack_s)
  );

  // Ready is derived from the registered count only, so a full FIFO never
  // accepts a word even when the FSM pops on the same edge.
  assign in_ready = rstn && (count < CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (state == IDLE) && (count != '0) && !ack_s;
  assign busy     = (state != IDLE) || (count != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // data_o is only loaded on IDLE->SETUP, which keeps the bundle stable from
  // the setup window until the receiver has released ack.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= IDLE;
      req_o  <= 1'b0;
      data_o <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            data_o <= mem[rd_ptr];
            cnt    <= CNT_W'(SETUP_CYC - 1);
            state  <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            req_o <= 1'b1;
            state <= REQ_HI;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        REQ_HI: begin
          if (ack_s) begin
            req_o <= 1'b0;
            state <= REQ_LO;
          end
        end
        REQ_LO: begin
          if (!ack_s) state <= IDLE;
        end
        default: begin
          req_o <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hs4_tx_bridge.sv
// tb_hs4_tx_bridge: directed self-checking bench for hs4_tx_bridge (default and
// SETUP_CYC=1/SYNC_STAGES=3 instances).
`default_nettype none

module tb_hs4_tx_bridge;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;

  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       req_o;
  logic [7:0] data_o;
  logic       ack_i;
  logic       busy;
  logic [2:0] count;

  logic       in_valid2 = 1'b0;
  logic       in_ready2;
  logic [7:0] in_data2 = '0;
  logic       req2;
  logic [7:0] data2;
  logic       ack2;
  logic       busy2;
  logic [2:0] count2;

  int errors = 0;
  int checks = 0;

  logic       rx_auto = 1'b1;
  logic       ack_force = 1'b0;
  int         rc1 = 0;
  int         rc2 = 0;
  logic [7:0] log1[$];
  logic [7:0] log2[$];

  always #5 clk = ~clk;

  hs4_tx_bridge dut (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .req_o    (req_o),
    .data_o   (data_o),
    .ack_i    (ack_i),
    .busy     (busy),
    .count    (count)
  );

  hs4_tx_bridge #(
    .WIDTH       (8),
    .DEPTH       (4),
    .SYNC_STAGES (3),
    .SETUP_CYC   (1)
  ) dut2 (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (in_valid2),
    .in_ready (in_ready2),
    .in_data  (in_data2),
    .req_o    (req2),
    .data_o   (data2),
    .ack_i    (ack2),
    .busy     (busy2),
    .count    (count2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle1(input string tag);
    int n;
    n = 0;
    while (busy && n < 600) begin
      tick();
      n++;
    end
    check(tag, busy, 0);
  endtask

  // Receiver models: echo req onto ack a fixed number of cycles later.
  initial begin
    ack_i = 1'b0;
    ack2  = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!rx_auto) begin
        ack_i = ack_force;
        rc1 = 0;
      end else if (ack_i == req_o) begin
        rc1 = 0;
      end else begin
        rc1++;
        if (rc1 == 3) begin
          if (req_o) log1.push_back(data_o);
          ack_i = req_o;
          rc1 = 0;
        end
      end
      if (ack2 == req2) begin
        rc2 = 0;
      end else begin
        rc2++;
        if (rc2 == 2) begin
          if (req2) log2.push_back(data2);
          ack2 = req2;
          rc2 = 0;
        end
      end
    end
  end

  // Bundling check: data_o must not move while req or the synchronised ack is high.
  logic [3:0] ah1 = '0;
  logic [3:0] ah2 = '0;
  logic [7:0] pd1 = '0;
  logic [7:0] pd2 = '0;
  logic       pr1 = 1'b0;
  logic       pr2 = 1'b0;
  logic       prst = 1'b0;
  int         viol1 = 0;
  int         viol2 = 0;

  always @(negedge clk) begin
    if (rstn && prst && (data_o != pd1) && (pr1 || (|ah1[1:0]))) viol1++;
    if (rstn && prst && (data2 != pd2) && (pr2 || (|ah2[2:0]))) viol2++;
    ah1  <= {ah1[2:0], ack_i};
    ah2  <= {ah2[2:0], ack2};
    pd1  <= data_o;
    pd2  <= data2;
    pr1  <= req_o;
    pr2  <= req2;
    prst <= rstn;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         idx;
    int         n;
    logic       acc;
    logic       seen;
    logic [7:0] exp_q[$];

    // Reset state
    rstn = 1'b0;
    tick();
    tick();
    check("rst_req", req_o, 0);
    check("rst_data", data_o, 0);
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", in_ready, 0);
    rstn = 1'b1;
    #1;
    check("post_rst_ready", in_ready, 1);

    // Single word A5
    in_valid = 1'b1;
    in_data  = 8'hA5;
    tick();                       // E0
    in_valid = 1'b0;
    check("sw_count_E0", count, 1);
    tick();                       // E1
    check("sw_data_E1", data_o, 8'hA5);
    check("sw_req_E1", req_o, 0);
    check("sw_count_E1", count, 0);
    check("sw_busy_E1", busy, 1);
    tick();                       // E2
    check("sw_req_E2", req_o, 0);
    tick();                       // E3
    check("sw_req_E3", req_o, 1);
    n = 0;
    while (!ack_i && n < 20) begin
      tick();
      n++;
    end
    check("sw_ack_seen", ack_i, 1);
    n = 0;
    while (req_o && n < 20) begin
      tick();
      n++;
    end
    check("sw_req_fall_edges", n, 2);
    wait_idle1("sw_idle");
    check("sw_data_hold", data_o, 8'hA5);
    check("sw_count_end", count, 0);

    // Burst of 6 with the receiver stalled
    rx_auto   = 1'b0;
    ack_force = 1'b0;
    idx       = 0;
    in_valid  = 1'b1;
    in_data   = 8'h01;
    repeat (8) begin
      acc = in_ready;
      tick();
      if (acc && idx < 6) begin
        idx++;
        in_data = 8'(idx + 1);
      end
    end
    check("burst_accepted", idx, 5);
    check("burst_count", count, 4);
    check("burst_ready", in_ready, 0);
    check("burst_req_stall", req_o, 1);
    log1.delete();
    rx_auto = 1'b1;
    n = 0;
    while (idx < 6 && n < 200) begin
      acc = in_ready;
      tick();
      n++;
      if (acc) begin
        idx++;
        in_data = 8'(idx + 1);
      end
    end
    in_valid = 1'b0;
    check("burst_all_accepted", idx, 6);
    wait_idle1("burst_idle");
    check("burst_log_size", log1.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < log1.size()) check($sformatf("burst_word%0d", i), log1[i], 8'(i + 1));
    end

    // Push and pop on the same edge with count==2, write pointer wrapping
    rx_auto   = 1'b0;
    ack_force = 1'b1;
    repeat (4) tick();
    in_valid = 1'b1;
    in_data  = 8'h11;
    tick();
    in_data  = 8'h22;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    check("pp_count_held", count, 2);
    check("pp_no_pop", data_o, 8'h06);
    ack_force = 1'b0;
    repeat (2) tick();
    check("pp_count_pre", count, 2);
    check("pp_data_pre", data_o, 8'h06);
    in_valid = 1'b1;
    in_data  = 8'h33;
    tick();                       // pop edge
    in_valid = 1'b0;
    check("pp_count_same_edge", count, 2);
    check("pp_data_pop", data_o, 8'h11);
    log1.delete();
    rx_auto = 1'b1;
    wait_idle1("pp_idle");
    exp_q = '{8'h11, 8'h22, 8'h33};
    check("pp_log_size", log1.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < log1.size()) check($sformatf("pp_word%0d", i), log1[i], exp_q[i]);
    end

    // ack_i held high through and after reset, FIFO loaded afterwards
    rx_auto   = 1'b0;
    ack_force = 1'b1;
    tick();
    rstn = 1'b0;
    tick();
    tick();
    check("ska_rst_count", count, 0);
    check("ska_rst_data", data_o, 0);
    rstn = 1'b1;
    repeat (3) tick();
    in_valid = 1'b1;
    in_data  = 8'h44;
    tick();
    in_data  = 8'h55;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check("ska_req_low", req_o, 0);
    check("ska_no_pop", count, 2);
    check("ska_data_zero", data_o, 0);
    check("ska_busy", busy, 1);
    ack_force = 1'b0;
    n = 0;
    while (!req_o && n < 20) begin
      tick();
      n++;
    end
    check("ska_req_latency", n, 5);
    check("ska_first_word", data_o, 8'h44);

    // Reset while in REQ_HI
    check("rhi_in_req", req_o, 1);
    rstn = 1'b0;
    tick();
    check("rhi_req", req_o, 0);
    check("rhi_data", data_o, 0);
    check("rhi_count", count, 0);
    rstn = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      tick();
      seen = seen | req_o;
    end
    check("rhi_no_stale_req", seen, 0);
    check("rhi_busy", busy, 0);

    // SETUP_CYC=1, SYNC_STAGES=3 instance
    in_valid2 = 1'b1;
    in_data2  = 8'h3C;
    tick();                       // E0
    in_valid2 = 1'b0;
    check("v_count_E0", count2, 1);
    tick();                       // E1
    check("v_data_E1", data2, 8'h3C);
    check("v_req_E1", req2, 0);
    tick();                       // E2
    check("v_req_E2", req2, 1);
    n = 0;
    while (busy2 && n < 200) begin
      tick();
      n++;
    end
    check("v_idle", busy2, 0);
    check("v_log_size", log2.size(), 1);
    if (log2.size() > 0) check("v_word", log2[0], 8'h3C);

    check("dstable_dut", viol1, 0);
    check("dstable_dut2", viol2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hs4_tx_bridge.md
# hs4_tx_bridge

Bridge from a clocked valid/ready source into a 4-phase bundled-data asynchronous channel (req/ack), sitting directly upstream of the first C-element stage of a micropipeline. Words accepted on the synchronous side are buffered in a small FIFO. Each word is then driven onto data_o, held for a programmable bundling-delay, and signalled with a full return-to-zero req/ack cycle. ack_i is asynchronous and is synchronised internally.

## Interface
- WIDTH, 8: data word width.
- DEPTH, 4: FIFO entries; power of two, ≥2.
- SYNC_STAGES, 2: flops in the ack_i synchroniser; ≥2.
- SETUP_CYC, 2: cycles data_o is stable before req_o rises (bundling margin); ≥1.
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- in_valid  in  1  source word valid.
- in_ready  out  1  FIFO can accept.
- in_data  in  WIDTH  source word.
- req_o  out  1  4-phase request to the async pipeline.
- data_o  out  WIDTH  bundled data to the async pipeline.
- ack_i  in  1  4-phase acknowledge from the async pipeline (asynchronous).
- busy  out  1  FSM not in IDLE, or FIFO non-empty.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- Reset (rstn=0 at a clk edge): req_o=0, data_o=0, FIFO emptied (pointers=0, count=0), in_ready=0 during reset and 1 afterward, busy=0, FSM=IDLE, synchroniser flops=0, setup counter=0.
- FIFO:
  - Push when in_valid & in_ready; in_ready = (count < DEPTH), registered-count based, so there is no push-through when full.
  - Pop happens only on the IDLE→SETUP transition.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers are log2(DEPTH) bits and wrap naturally.
- ack_s = ack_i after SYNC_STAGES flops. The FSM uses only ack_s.
- FSM:
  - IDLE: if count≠0 and ack_s==0, pop the head into data_o, load cnt=SETUP_CYC-1, go to SETUP. Otherwise stay. The ack_s==0 guard prevents a new request while the receiver is still releasing a previous ack, including after a reset with ack_i stuck high.
  - SETUP: req_o=0 and data_o held. If cnt==0, set req_o=1 and go to REQ_HI; else cnt−1.
  - REQ_HI: req_o=1 and data_o held. On ack_s==1, clear req_o and go to REQ_LO.
  - REQ_LO: req_o=0 and data_o held. On ack_s==0, go to IDLE.
- data_o changes only on the IDLE→SETUP transition, so it is stable from SETUP_CYC cycles before req_o rises until after ack falls.
- Reset mid-handshake abandons the word in flight and the FIFO contents. The downstream C-elements share rstn and must be reset in the same window; the IDLE guard covers residual ack.

## Timing
- Word accepted at edge E0: it is in the FIFO at E0 and popped at E1 (if the FSM is in IDLE and ack_s=0). data_o is valid after E1, and req_o rises at edge E1+SETUP_CYC.
- ack_i rising between edges Ek-1 and Ek makes ack_s high after edge Ek+SYNC_STAGES-1. req_o falls at Ek+SYNC_STAGES.
- ack_i falling resolves the same way and returns the FSM to IDLE. The next pop happens one edge later.
- Minimum sync-side cycles per word: 1 (IDLE) + SETUP_CYC + 2·SYNC_STAGES + receiver delay.
- in_ready responds to a pop one cycle after the pop edge.

## Structure
- Package hs4_pkg: FSM state encoding (IDLE=2'd0, SETUP=2'd1, REQ_HI=2'd2, REQ_LO=2'd3) and a clog2 helper. These are shared with the future receive-side bridge.
- Sub-module sync_nff: SYNC_STAGES-deep, 1-bit synchroniser with synchronous active-low reset to 0.
- The FIFO, setup counter and FSM are inline in hs4_tx_bridge.

## Test plan
- Single word 8'hA5, defaults, receiver model acks 3 cycles after req and drops ack 3 cycles after req falls:
  - data_o=A5 at E1, req_o high at E3.
  - req_o low exactly SYNC_STAGES edges after ack_i rises.
  - busy low once back in IDLE with the FIFO empty.
- Burst of 6 words 01..06 with the receiver stalled (ack never rises):
  - in_ready drops after 4 accepted words plus 1 popped, so count==4.
  - After the receiver is released, data arrives in order 01..06 with no loss or duplication.
- Push and pop on the same edge with count==2: count stays 2, and the pointer wrap past DEPTH-1 is exercised.
- Hold ack_i=1 through and after reset with the FIFO loaded:
  - req_o stays 0 and there is no pop.
  - When ack_i drops, the first req rises 1+SYNC_STAGES+SETUP_CYC edges later.
- Assert rstn=0 while in REQ_HI:
  - Next edge: req_o=0, data_o=0, count=0.
  - No req for stale data after reset release.
- SETUP_CYC=1, SYNC_STAGES=3 variant: req_o rises at E2, and data_o never changes while req_o or ack_s is high (assertion).
